// File: rtl/lat_tester_ctrl_if.sv
// lat_tester_ctrl_if: host, video-generator and sensor signals of the latency tester.
interface lat_tester_ctrl_if;
  logic        start;
  logic        abort;
  logic [1:0]  pos_sel;
  logic        vsync_in;
  logic        sensor_in;
  logic        lt_active;
  logic [1:0]  lt_mode;
  logic        busy;
  logic [15:0] result;
  logic        timeout;
  logic        result_valid;
  modport master (
    output start, abort, pos_sel, vsync_in, sensor_in,
    input  lt_active, lt_mode, busy, result, timeout, result_valid
  );
  modport slave (
    input  start, abort, pos_sel, vsync_in, sensor_in,
    output lt_active, lt_mode, busy, result, timeout, result_valid
  );
endinterface

// File: rtl/lat_tester_ctrl.sv
// lat_tester_ctrl: blanks the screen, shows a box at a frame boundary and times the photodiode response in us.
module lat_tester_ctrl #(
  parameter int          SETTLE_FRAMES = 3,
  parameter int          US_DIV        = 27,
  parameter logic [15:0] TIMEOUT_US    = 16'd50000,
  parameter logic [7:0]  DEBOUNCE      = 8'd54
) (
  input logic              clk27,
  input logic              reset,
  lat_tester_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, RELEASE} state_t;
  state_t      r_state, w_state;
  logic        r_s1, r_s2, r_deb, r_vs, r_vs_prev, w_fe;
  logic        r_dark, w_dark, r_timeout, w_timeout, r_rv, w_rv;
  logic [7:0]  r_db_cnt, r_frm, w_frm;
  logic [1:0]  r_pos, w_pos, r_mode, w_mode;
  logic [15:0] r_us, w_us, r_pre, w_pre, r_result, w_result;
  assign w_fe = r_vs_prev & ~r_vs;
  always_ff @(posedge clk27) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_db_cnt  <= 8'd0;
      r_deb     <= 1'b0;
      r_vs      <= 1'b0;
      r_vs_prev <= 1'b0;
      r_state   <= IDLE;
      r_pos     <= 2'd0;
      r_frm     <= 8'd0;
      r_mode    <= 2'd0;
      r_us      <= 16'd0;
      r_pre     <= 16'd0;
      r_result  <= 16'd0;
      r_timeout <= 1'b0;
      r_rv      <= 1'b0;
      r_dark    <= 1'b0;
    end else begin
      r_s1      <= bus.sensor_in;
      r_s2      <= r_s1;
      r_db_cnt  <= !r_s2 ? 8'd0 : (r_db_cnt == DEBOUNCE ? r_db_cnt : r_db_cnt + 8'd1);
      r_deb     <= r_s2 && ({1'b0, r_db_cnt} + 9'd1 >= {1'b0, DEBOUNCE});
      r_vs      <= bus.vsync_in;
      r_vs_prev <= r_vs;
      r_state   <= w_state;
      r_pos     <= w_pos;
      r_frm     <= w_frm;
      r_mode    <= w_mode;
      r_us      <= w_us;
      r_pre     <= w_pre;
      r_result  <= w_result;
      r_timeout <= w_timeout;
      r_rv      <= w_rv;
      r_dark    <= w_dark;
    end
  end
  always_comb begin
    w_state   = r_state;
    w_pos     = r_pos;
    w_frm     = r_frm;
    w_mode    = r_mode;
    w_us      = r_us;
    w_pre     = r_pre;
    w_result  = r_result;
    w_timeout = r_timeout;
    w_rv      = 1'b0;
    w_dark    = r_dark;
    if (bus.abort) begin
      w_state = IDLE;
      w_mode  = 2'd0;
    end else begin
      case (r_state)
        IDLE: if (bus.start && bus.pos_sel != 2'd0) begin
          w_state = SETTLE;
          w_pos   = bus.pos_sel;
          w_frm   = 8'd0;
        end
        SETTLE: if (w_fe) begin
          // a lit sensor at a boundary means the screen is not dark yet: restart the count
          w_frm = r_deb ? 8'd0 : r_frm + 8'd1;
          if (!r_deb && r_frm + 8'd1 == 8'(SETTLE_FRAMES)) begin
            w_state = MEASURE;
            w_mode  = r_pos;
            w_us    = 16'd0;
            w_pre   = 16'd0;
          end
        end
        MEASURE: begin
          w_pre = r_pre == 16'(US_DIV - 1) ? 16'd0 : r_pre + 16'd1;
          w_us  = (r_pre == 16'(US_DIV - 1) && r_us != TIMEOUT_US) ? r_us + 16'd1 : r_us;
          if (r_deb || r_us == TIMEOUT_US) begin
            w_result  = r_deb ? r_us : TIMEOUT_US;
            w_timeout = !r_deb;
            w_rv      = 1'b1;
            w_state   = RELEASE;
            w_mode    = 2'd0;
            w_dark    = 1'b0;
          end
        end
        RELEASE: begin
          w_dark = r_dark | ~r_deb;
          if (r_dark && w_fe) w_state = IDLE;
        end
      endcase
    end
  end
  assign bus.busy         = r_state != IDLE;
  assign bus.lt_active    = r_state != IDLE;
  assign bus.lt_mode      = r_mode;
  assign bus.result       = r_result;
  assign bus.timeout      = r_timeout;
  assign bus.result_valid = r_rv;
endmodule

// File: tb/tb_lat_tester_ctrl.sv
// tb_lat_tester_ctrl: directed runs with a result scoreboard checked by an independent strobe monitor.
module tb_lat_tester_ctrl;
  logic clk27 = 1'b0;
  logic reset = 1'b1;
  lat_tester_ctrl_if ifc();
  lat_tester_ctrl #(
    .SETTLE_FRAMES(3),
    .US_DIV(4),
    .TIMEOUT_US(16'd200),
    .DEBOUNCE(8'd6)
  ) dut (
    .clk27(clk27),
    .reset(reset),
    .bus(ifc)
  );
  always #5 clk27 = ~clk27;
  int tests = 0;
  int fails = 0;
  int vcnt = 0;
  int falls = 0;
  int c0, n;
  logic [16:0] q[$];
  logic [16:0] exp_e;
  logic prev_rv = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_vcnt(input int v);
    do @(negedge clk27); while (vcnt != v);
  endtask
  task automatic wait_mode(input string name, input logic [1:0] m, input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk27);
      cyc++;
    end while (ifc.lt_mode !== m && cyc < lim);
    if (ifc.lt_mode !== m) chk(name, int'(ifc.lt_mode), int'(m));
  endtask
  task automatic wait_idle(input string name, input int lim);
    int c = 0;
    do begin
      @(negedge clk27);
      c++;
    end while (ifc.busy !== 1'b0 && c < lim);
    chk(name, int'(ifc.busy), 0);
  endtask
  task automatic pulse_start(input logic [1:0] p);
    ifc.pos_sel = p;
    ifc.start   = 1'b1;
    @(negedge clk27);
    ifc.start   = 1'b0;
  endtask
  // 64-cycle frames, vsync low for the first 4 cycles; inputs change 2 time units after posedge
  initial begin
    ifc.vsync_in = 1'b1;
    forever begin
      @(posedge clk27);
      #2;
      vcnt = (vcnt == 63) ? 0 : vcnt + 1;
      ifc.vsync_in = (vcnt >= 4);
      if (vcnt == 0) falls++;
    end
  end
  initial begin
    forever begin
      @(negedge clk27);
      if (ifc.result_valid) begin
        if (prev_rv) chk("strobe_one_cycle", 1, 0);
        if (q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          exp_e = q.pop_front();
          chk("sb_result", int'(ifc.result), int'(exp_e[15:0]));
          chk("sb_timeout", int'(ifc.timeout), int'(exp_e[16]));
          chk("sb_mode_off", int'(ifc.lt_mode), 0);
        end
      end
      prev_rv = ifc.result_valid;
    end
  end
  initial begin
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.pos_sel = 2'd0;
    ifc.sensor_in = 1'b0;
    repeat (3) @(negedge clk27);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_active", int'(ifc.lt_active), 0);
    chk("rst_mode", int'(ifc.lt_mode), 0);
    chk("rst_result", int'(ifc.result), 0);
    chk("rst_timeout", int'(ifc.timeout), 0);
    chk("rst_rv", int'(ifc.result_valid), 0);
    reset = 1'b0;
    // run A: normal hit, second start ignored, release holds while sensor lit
    wait_vcnt(20);
    c0 = falls;
    pulse_start(2'd2);
    chk("A_busy", int'(ifc.busy), 1);
    chk("A_active", int'(ifc.lt_active), 1);
    chk("A_mode_dark", int'(ifc.lt_mode), 0);
    wait_vcnt(30);
    pulse_start(2'd3);
    ifc.pos_sel = 2'd0;
    wait_mode("A_box_on", 2'd2, 400, n);
    chk("A_box_pos", int'(ifc.lt_mode), 2);
    chk("A_settle_frames", falls - c0, 3);
    q.push_back({1'b0, 16'd27});
    repeat (100) @(negedge clk27);
    ifc.sensor_in = 1'b1;
    wait_mode("A_hit", 2'd0, 100, n);
    wait_vcnt(20);
    wait_vcnt(20);
    chk("A_release_hold", int'(ifc.busy), 1);
    ifc.sensor_in = 1'b0;
    wait_vcnt(60);
    chk("A_release_wait_frame", int'(ifc.busy), 1);
    wait_vcnt(5);
    chk("A_idle", int'(ifc.busy), 0);
    chk("A_idle_active", int'(ifc.lt_active), 0);
    // run B: no sensor response, timeout after 200 us = 801 cycles
    wait_vcnt(20);
    pulse_start(2'd1);
    wait_mode("B_box_on", 2'd1, 400, n);
    q.push_back({1'b1, 16'd200});
    wait_mode("B_timeout", 2'd0, 1000, n);
    chk("B_timeout_cycles", n, 801);
    chk("B_busy_release", int'(ifc.busy), 1);
    wait_vcnt(5);
    chk("B_idle", int'(ifc.busy), 0);
    // run C: sensor lit while settling, then glitch and abort during measure
    wait_vcnt(10);
    ifc.sensor_in = 1'b1;
    wait_vcnt(20);
    pulse_start(2'd3);
    repeat (5) wait_vcnt(20);
    chk("C_settle_held", int'(ifc.lt_mode), 0);
    chk("C_settle_busy", int'(ifc.busy), 1);
    ifc.sensor_in = 1'b0;
    c0 = falls;
    wait_mode("C_box_on", 2'd3, 400, n);
    chk("C_settle_after_dark", falls - c0, 3);
    repeat (10) @(negedge clk27);
    ifc.sensor_in = 1'b1;
    repeat (3) @(negedge clk27);
    ifc.sensor_in = 1'b0;
    repeat (20) @(negedge clk27);
    chk("C_glitch_no_hit", int'(ifc.lt_mode), 3);
    ifc.abort = 1'b1;
    @(negedge clk27);
    ifc.abort = 1'b0;
    chk("C_abort_busy", int'(ifc.busy), 0);
    chk("C_abort_mode", int'(ifc.lt_mode), 0);
    chk("C_abort_result", int'(ifc.result), 200);
    chk("C_abort_timeout", int'(ifc.timeout), 1);
    // run D: start with no position ignored, then a short hit
    wait_vcnt(20);
    pulse_start(2'd0);
    chk("D_pos0_ignored", int'(ifc.busy), 0);
    wait_vcnt(20);
    pulse_start(2'd1);
    wait_mode("D_box_on", 2'd1, 400, n);
    q.push_back({1'b0, 16'd12});
    repeat (41) @(negedge clk27);
    ifc.sensor_in = 1'b1;
    wait_mode("D_hit", 2'd0, 100, n);
    ifc.sensor_in = 1'b0;
    wait_idle("D_idle", 200);
    // run E: synchronous reset while measuring
    wait_vcnt(20);
    pulse_start(2'd2);
    wait_mode("E_box_on", 2'd2, 400, n);
    repeat (30) @(negedge clk27);
    reset = 1'b1;
    @(negedge clk27);
    chk("E_rst_busy", int'(ifc.busy), 0);
    chk("E_rst_active", int'(ifc.lt_active), 0);
    chk("E_rst_mode", int'(ifc.lt_mode), 0);
    chk("E_rst_result", int'(ifc.result), 0);
    chk("E_rst_timeout", int'(ifc.timeout), 0);
    chk("E_rst_rv", int'(ifc.result_valid), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk27);
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lat_tester_ctrl.md
# lat_tester_ctrl

Sequencer for the latency-test mode of the pattern generator. On a start request it blanks the screen, waits for the display to settle, then switches on a white box at a frame boundary. It times, in microseconds, how long the photodiode sensor takes to see the box. It drives `lt_active`/`lt_mode` of the video generator and reports the measurement and a timeout flag to the host interface.

## Interface
Parameters
- `SETTLE_FRAMES`, default 3: full black frames shown before the box is enabled.
- `US_DIV`, default 27: clk27 cycles per microsecond tick.
- `TIMEOUT_US`, default 16'd50000: measurement ceiling in µs.
- `DEBOUNCE`, default 8'd54: consecutive synced-high sensor cycles required to count as a hit.

Ports
- `clk27`  in  1  27 MHz pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; honoured only in IDLE with `pos_sel != 0`.
- `abort`  in  1  level; returns to IDLE from any state.
- `pos_sel`  in  2  box position: 1 top-left, 2 center, 3 bottom-right, 0 none. This is the shared LT_POS encoding.
- `vsync_in`  in  1  VSYNC from the video generator, negative polarity, clk27-synchronous.
- `sensor_in`  in  1  photodiode comparator, asynchronous, high = bright.
- `lt_active`  out  1  latency-test mode enable to the video generator.
- `lt_mode`  out  2  box position to the video generator; 0 = all black.
- `busy`  out  1  high in every state except IDLE.
- `result`  out  16  last latency in µs; holds until the next completed or timed-out run.
- `timeout`  out  1  set when the last run hit `TIMEOUT_US`.
- `result_valid`  out  1  one-cycle strobe when `result`/`timeout` update.

## Operation
- `sensor_in` passes through a 2-FF synchroniser, then a debouncer. The debounced level goes high after `DEBOUNCE` consecutive high samples and low on the first low sample.
- Frame boundary = falling edge of registered `vsync_in` (previous 1, current 0).
- The µs prescaler counts 0..US_DIV-1. It is cleared whenever the µs counter is cleared, and it increments the µs counter on wrap.
- States:
  - IDLE: `lt_active`=0, `lt_mode`=0. On `start` with nonzero `pos_sel`, latch `pos_sel` and go to SETTLE, frame counter = 0.
  - SETTLE: `lt_active`=1, `lt_mode`=0. Each frame boundary increments the frame counter.
    - If the debounced sensor is high at a boundary, reset the frame counter to 0, because the screen is not yet dark.
    - When the counter reaches `SETTLE_FRAMES` on a boundary, go to MEASURE on the next cycle.
    - On that same boundary cycle, set `lt_mode` to the latched position and clear the µs counter and prescaler.
  - MEASURE: µs counter runs.
    - Debounced sensor high: `result` = µs counter, `timeout`=0, pulse `result_valid`, go to RELEASE.
    - µs counter reaches `TIMEOUT_US`: `result` = `TIMEOUT_US`, `timeout`=1, pulse `result_valid`, go to RELEASE.
    - If hit and timeout occur in the same cycle, the hit wins.
  - RELEASE: `lt_mode`=0, `lt_active`=1. Wait for the debounced sensor to be low, then one more frame boundary, then go to IDLE.
- `abort`: next state is IDLE from any state; `result`, `timeout` and `result_valid` are not updated. `abort` has priority over `start` and over hit/timeout in the same cycle.
- `start` outside IDLE is ignored. `start` with `pos_sel`=0 is ignored.
- Arithmetic: the µs counter is 16 bits and never wraps, because the timeout check precedes overflow. The frame counter is 8 bits.

## Timing
- Reset values: `lt_active`=0, `lt_mode`=0, `busy`=0, `result`=0, `timeout`=0, `result_valid`=0. State is IDLE and all counters and synchroniser flops are 0.
- Outputs are registered.
- `busy` and `lt_active` rise 1 cycle after the accepted `start`.
- `lt_mode` changes 1 cycle after the registered falling edge of `vsync_in`, so 2 cycles after the input edge.
- Sensor-to-hit latency is 2 (sync) + `DEBOUNCE` cycles. This offset is included in `result`; no correction is applied.
- `result_valid` is high for exactly one cycle, coincident with the new `result`.
- Reset asserted mid-run forces all outputs to their reset values on the next edge.

## Test plan
- Reset, then `start` with `pos_sel`=2 and sensor low → `busy`/`lt_active` high next cycle, `lt_mode`=0 for 3 frames, `lt_mode`=2 after the 3rd VSYNC falling edge.
- Continuing: sensor high 1000 µs (27000 cycles) after the box enable → `result_valid` pulse with `result` = 1000+(2+54)/27 → 1002 (±1), `timeout`=0, `lt_mode`=0.
- Sensor never rises → after 50000 µs, `result`=50000, `timeout`=1, one `result_valid` pulse. Raise the sensor, then drop it → IDLE after the next frame boundary, `busy`=0.
- Sensor held high during SETTLE for 5 frames, then low → the box enables only 3 boundaries after the sensor goes low.
- Sensor glitch of 20 cycles high during MEASURE → no hit. `abort` mid-MEASURE → IDLE next cycle, `result` unchanged, no strobe.
- `start` with `pos_sel`=0, and `start` while busy → no state change. Synchronous `reset` mid-MEASURE → all outputs 0 next edge.
